dbscan_point_store: RTL
=======================

// Module: dbscan_point_store
// PURPOSE
//  Parametrised point/label store for the DBSCAN core. Holds up to MAX_N 3-D points plus per-point cluster
//  label and core flag. Adds a valid/ready load stream with point counting, a bulk label-clear sequencer and
//  registered dual read ports with write-first label bypass. Sits between the LiDAR frame loader and the
//  neighbourhood/expansion FSM.
// PARAMETERS
//  MAX_N    64  point capacity; AW = $clog2(MAX_N) address bits, CW = AW+1 count bits
//  COORD_W  8   bits per coordinate (x, y, z unsigned)
//  LABEL_W  4   cluster label width; label 0 = unassigned/noise
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  load_start  in   1        pulse: restart frame load at address 0
//  s_valid     in   1        stream point valid
//  s_ready     out  1        store accepts point
//  s_last      in   1        last point of frame (qualified by s_valid&s_ready)
//  s_x/s_y/s_z in   COORD_W  stream coordinates
//  load_done   out  1        1-cycle pulse: load finished
//  n_points    out  CW       points stored in current frame
//  clear_start in   1        pulse: zero all label/core(/visited) entries
//  clear_done  out  1        1-cycle pulse: clear finished
//  busy        out  1        high in LOAD or CLEAR
//  rd_en_i     in   1        read-enable port I;  raddr_i in AW
//  xi/yi/zi    out  COORD_W  port I coords (1-cycle latency)
//  li          out  LABEL_W  port I label;  core_i out 1 core flag;  vis_i out 1 visited flag
//  rd_en_j     in   1        read-enable port J;  raddr_j in AW;  xj/yj/zj out COORD_W
//  we_label    in   1        label write;  we_core in 1;  we_vis in 1
//  waddr       in   AW       label/core/visited write address
//  wlabel      in   LABEL_W  / wcore in 1 / wvis in 1  write data
// BEHAVIOUR
//  Reset: all outputs 0 (s_ready 0), state IDLE, n_points 0; label/core/visited arrays async-cleared to 0;
//   coordinate arrays not reset (contents undefined until loaded).
//  FSM IDLE/LOAD/CLEAR (encoding in package). In IDLE, clear_start has priority over load_start.
//  IDLE->LOAD on load_start: wr_ptr<=0, n_points<=0. LOAD: s_ready=1 while n_points<MAX_N;
//   each accepted beat writes coords at wr_ptr, wr_ptr++, n_points++ the following cycle.
//  LOAD->IDLE when accepted beat has s_last, or accepted beat makes n_points==MAX_N; load_done pulses
//   on the transition cycle; further s_valid beats are not accepted (s_ready=0 in IDLE/CLEAR).
//  load_start during LOAD restarts (wr_ptr/n_points back to 0, no load_done). clear_start in LOAD ignored.
//  IDLE->CLEAR on clear_start: counter 0..MAX_N-1 zeroes one entry per cycle (MAX_N cycles), then IDLE
//   with clear_done pulse. load_start in CLEAR ignored.
//  we_label/we_core/we_vis are ignored during CLEAR; honoured in IDLE and LOAD.
//  Reads: on rd_en_x, output registers load array[raddr_x] next edge; rd_en low holds previous value.
//  Write-first bypass on port I: same-cycle write with waddr==raddr_i returns the new label/core/vis.
//  No coordinate bypass: reading the address being loaded this cycle returns previous contents.
//  Ports I/J may read the same address simultaneously; both return identical data.
//  rst_n low mid-LOAD/CLEAR aborts immediately; no done pulse is produced.
// CONFIGURATION
//  DBSCAN_VISITED_EN defined: per-point visited bit array, written via we_vis/wvis, cleared by clear
//   sequence and reset, read on vis_i with port I timing/bypass.
//  Not defined: no visited storage; vis_i constant 0; we_vis/wvis ignored (ports remain).
// STRUCTURE
//  dbscan_pkg: FSM state typedef (ST_IDLE/ST_LOAD/ST_CLEAR), default MAX_N/COORD_W/LABEL_W constants,
//   LABEL_NOISE = 0.
//  Sub-module dbscan_ram_1w2r: coordinate storage, one write port, two registered read ports.
//  Label/core/visited arrays, bypass, FSM and counters stay in this module.
// TESTING
//  Load 5 beats (1,2,3)..(5,6,7), s_last on 5th -> load_done 1 pulse, n_points=5, read addr 4 -> (5,6,7).
//  Stream MAX_N+3 beats, no s_last -> s_ready drops after 64th, load_done once, n_points=64.
//  Write label 3 to addr 7 -> clear_start -> busy 64 cycles, clear_done, read addr 7 -> li=0, core_i=0.
//  Same cycle we_label addr 9 wlabel=6 and rd_en_i raddr_i=9 -> li=6 next cycle (bypass).
//  clear_start and load_start same cycle in IDLE -> CLEAR entered, s_ready stays 0 until clear_done.
//  rst_n low mid-LOAD after 3 beats -> outputs 0, n_points 0, no load_done; vis_i=0 without DBSCAN_VISITED_EN.

Source files
------------

// File: rtl/dbscan_pkg.sv
// Shared types and default sizing for the DBSCAN point store.
package dbscan_pkg;

  localparam int unsigned MAX_N_DEF   = 64;
  localparam int unsigned COORD_W_DEF = 8;
  localparam int unsigned LABEL_W_DEF = 4;

  // Label value meaning unassigned / noise
  localparam int unsigned LABEL_NOISE = 0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_CLEAR = 2'd2;

endpackage

// File: rtl/dbscan_ram_1w2r.sv
// Coordinate storage: one write port, two registered read ports (read-before-write).
module dbscan_ram_1w2r #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned DW    = 24,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re_a,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic          re_b,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [DEPTH];

  // Array write; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Port A read register, holds when re_a is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_a <= '0;
    else if (re_a) rdata_a <= mem[raddr_a];
  end

  // Port B read register, holds when re_b is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_b <= '0;
    else if (re_b) rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/dbscan_point_store.sv
// Point/label store for the DBSCAN core: stream loader, bulk label clear,
// dual registered read ports with write-first label bypass on port I.
// Optional feature macro: DBSCAN_VISITED_EN adds a per-point visited bit.
module dbscan_point_store
  import dbscan_pkg::*;
#(
  parameter  int unsigned MAX_N   = MAX_N_DEF,
  parameter  int unsigned COORD_W = COORD_W_DEF,
  parameter  int unsigned LABEL_W = LABEL_W_DEF,
  localparam int unsigned AW      = $clog2(MAX_N),
  localparam int unsigned CW      = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  input  logic [COORD_W-1:0] s_x,
  input  logic [COORD_W-1:0] s_y,
  input  logic [COORD_W-1:0] s_z,
  output logic               load_done,
  output logic [CW-1:0]      n_points,
  input  logic               clear_start,
  output logic               clear_done,
  output logic               busy,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [COORD_W-1:0] xi,
  output logic [COORD_W-1:0] yi,
  output logic [COORD_W-1:0] zi,
  output logic [LABEL_W-1:0] li,
  output logic               core_i,
  output logic               vis_i,
  input  logic               rd_en_j,
  input  logic [AW-1:0]      raddr_j,
  output logic [COORD_W-1:0] xj,
  output logic [COORD_W-1:0] yj,
  output logic [COORD_W-1:0] zj,
  input  logic               we_label,
  input  logic               we_core,
  input  logic               we_vis,
  input  logic [AW-1:0]      waddr,
  input  logic [LABEL_W-1:0] wlabel,
  input  logic               wcore,
  input  logic               wvis
);

  localparam int unsigned  DW       = 3 * COORD_W;
  localparam logic [CW-1:0] N_FULL  = CW'(MAX_N);
  localparam logic [AW-1:0] CLR_LAST = AW'(MAX_N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] n_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          s_ready_d, load_done_d, clear_done_d, busy_d;
  logic          accept_c, clearing_c;

  logic [LABEL_W-1:0] label_mem [MAX_N];
  logic [MAX_N-1:0]   core_mem;

  logic               lbl_we_c, core_we_c;
  logic [AW-1:0]      lbl_addr_c;
  logic [LABEL_W-1:0] lbl_data_c;
  logic               core_data_c;

  logic [DW-1:0] rdata_i, rdata_j;

  assign accept_c   = (state_q == ST_LOAD) && s_valid && s_ready;
  assign clearing_c = (state_q == ST_CLEAR);

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_points   <= '0;
      clr_cnt_q  <= '0;
      s_ready    <= 1'b0;
      load_done  <= 1'b0;
      clear_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_points   <= n_d;
      clr_cnt_q  <= clr_cnt_d;
      s_ready    <= s_ready_d;
      load_done  <= load_done_d;
      clear_done <= clear_done_d;
      busy       <= busy_d;
    end
  end

  // Next-state, counter update and next values of the status outputs
  always_comb begin
    state_d      = state_q;
    n_d          = n_points;
    clr_cnt_d    = clr_cnt_q;
    load_done_d  = 1'b0;
    clear_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (load_start) begin
          state_d = ST_LOAD;
          n_d     = '0;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          n_d = '0;
        end else if (accept_c) begin
          n_d = n_points + CW'(1);
          if (s_last || (n_d == N_FULL)) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d      = ST_IDLE;
          clr_cnt_d    = '0;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    s_ready_d = (state_d == ST_LOAD) && (n_d < N_FULL);
    busy_d    = (state_d != ST_IDLE);
  end

  // Unified label/core write: clear sequencer overrides user writes
  always_comb begin
    lbl_we_c    = clearing_c | we_label;
    core_we_c   = clearing_c | we_core;
    lbl_addr_c  = clearing_c ? clr_cnt_q : waddr;
    lbl_data_c  = clearing_c ? LABEL_W'(LABEL_NOISE) : wlabel;
    core_data_c = clearing_c ? 1'b0 : wcore;
  end

  // Label array, async-cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_N; i++) label_mem[i] <= '0;
    end else if (lbl_we_c) begin
      label_mem[lbl_addr_c] <= lbl_data_c;
    end
  end

  // Core flag array, async-cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         core_mem <= '0;
    else if (core_we_c) core_mem[lbl_addr_c] <= core_data_c;
  end

  // Port I label/core read with write-first bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      li     <= '0;
      core_i <= 1'b0;
    end else if (rd_en_i) begin
      li     <= (lbl_we_c && (lbl_addr_c == raddr_i)) ? lbl_data_c : label_mem[raddr_i];
      core_i <= (core_we_c && (lbl_addr_c == raddr_i)) ? core_data_c : core_mem[raddr_i];
    end
  end

`ifdef DBSCAN_VISITED_EN
  logic [MAX_N-1:0] vis_mem;
  logic             vis_we_c, vis_data_c;

  assign vis_we_c   = clearing_c | we_vis;
  assign vis_data_c = clearing_c ? 1'b0 : wvis;

  // Visited flag array, async-cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        vis_mem <= '0;
    else if (vis_we_c) vis_mem[lbl_addr_c] <= vis_data_c;
  end

  // Port I visited read with write-first bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vis_i <= 1'b0;
    else if (rd_en_i) vis_i <= (vis_we_c && (lbl_addr_c == raddr_i)) ? vis_data_c : vis_mem[raddr_i];
  end
`else
  logic unused_vis;
  assign unused_vis = &{1'b0, we_vis, wvis};
  assign vis_i      = 1'b0;
`endif

  dbscan_ram_1w2r #(
    .DEPTH (MAX_N),
    .DW    (DW)
  ) u_coord_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept_c),
    .waddr   (n_points[AW-1:0]),
    .wdata   ({s_x, s_y, s_z}),
    .re_a    (rd_en_i),
    .raddr_a (raddr_i),
    .rdata_a (rdata_i),
    .re_b    (rd_en_j),
    .raddr_b (raddr_j),
    .rdata_b (rdata_j)
  );

  assign {xi, yi, zi} = rdata_i;
  assign {xj, yj, zj} = rdata_j;

endmodule
